// File: rtl/fifo_32b.sv
// Synchronous 32-bit FIFO with first-word fall-through head, occupancy count
// and sticky overflow/underflow error flags.
module fifo_32b #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  input  logic          clr_err
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_valid = ~empty;
  assign rd_data  = empty ? 32'h0 : mem[rp_q];
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

  // A full FIFO still takes a push when the head is popped in the same cycle.
  assign push_ok = wr_en & (~full | rd_en);
  assign pop_ok  = rd_en & ~empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop_ok)  rp_d = rp_q + AW'(1);
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
    // Set conditions win over a same-cycle clear.
    ovf_d = (wr_en & full & ~rd_en) | (ovf_q & ~clr_err);
    udf_d = (rd_en & empty) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately unreset; empty gates stale contents off rd_data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp_q] <= wr_data;
  end

endmodule

// File: tb/tb_fifo_32b.sv
// Directed self-checking bench for fifo_32b at DEPTH=4.
module tb_fifo_32b;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        ovf;
  logic        udf;
  logic        clr_err;

  int tests;
  int fails;

  fifo_32b #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf),
    .clr_err (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; clr_err = 1'b0;
    #1;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", rd_data); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if ({ovf, udf} !== 2'b00) begin fails++; $display("FAIL reset_err got %b exp 00", {ovf, udf}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_push();
    push(32'hA5A5_0001);
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", rd_valid); end
    tests++; if (rd_data !== 32'hA5A5_0001) begin fails++; $display("FAIL first_data got %h exp a5a50001", rd_data); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL first_count got %0d exp 1", count); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL first_drain got %b exp 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) push(32'(i));
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b exp 1", full); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count4 got %0d exp 4", count); end
    push(32'd5);
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", count); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    for (int i = 1; i <= 4; i++) begin
      tests++; if (rd_data !== 32'(i)) begin fails++; $display("FAIL ovf_pop%0d got %h exp %h", i, rd_data, 32'(i)); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'd2; exp_q[1] = 32'd3; exp_q[2] = 32'd4; exp_q[3] = 32'd9;
    for (int i = 1; i <= 4; i++) push(32'(i));
    tests++; if (rd_data !== 32'd1) begin fails++; $display("FAIL fpp_head got %h exp 1", rd_data); end
    wr_en = 1'b1; wr_data = 32'd9; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fpp_count got %0d exp 4", count); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL fpp_ovf got %b exp 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rd_data !== exp_q[i]) begin fails++; $display("FAIL fpp_pop%0d got %h exp %h", i, rd_data, exp_q[i]); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fpp_empty got %b exp 1", empty); end
  endtask

  task automatic test_empty_push_pop();
    wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    tests++; if (udf !== 1'b1) begin fails++; $display("FAIL epp_udf got %b exp 1", udf); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL epp_count got %0d exp 1", count); end
    tests++; if (rd_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL epp_data got %h exp deadbeef", rd_data); end
    rd_en = 1'b1; clr_err = 1'b1; step(); rd_en = 1'b0; clr_err = 1'b0;
    tests++; if ({udf, empty} !== 2'b01) begin fails++; $display("FAIL epp_clear got %b exp 01", {udf, empty}); end
  endtask

  task automatic test_stream();
    int pushed, popped, mcount, cycles;
    logic w, r;
    pushed = 0; popped = 0; mcount = 0; cycles = 0;
    while (popped < 20 && cycles < 400) begin
      r = (mcount > 0) && ($urandom_range(0, 1) == 1);
      w = (pushed < 20) && (mcount < int'(DEPTH) || r) && ($urandom_range(0, 1) == 1);
      wr_en = w; wr_data = 32'(pushed); rd_en = r;
      if (r) begin
        tests++; if (rd_data !== 32'(popped)) begin fails++; $display("FAIL stream_pop%0d got %h exp %h", popped, rd_data, 32'(popped)); end
      end
      step();
      if (w) begin pushed++; mcount++; end
      if (r) begin popped++; mcount--; end
      cycles++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tests++; if (popped != 20) begin fails++; $display("FAIL stream_timeout got %0d pops exp 20", popped); end
    tests++; if ({ovf, udf, empty} !== 3'b001) begin fails++; $display("FAIL stream_flags got %b exp 001", {ovf, udf, empty}); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(i));
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL ar_pre got %0d exp 3", count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL ar_count got %0d exp 0", count); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL ar_data got %h exp 0", rd_data); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b exp 0", rd_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h7);
    tests++; if (rd_data !== 32'h7 || count !== 3'd1) begin fails++; $display("FAIL ar_repush got %h/%0d exp 7/1", rd_data, count); end
    rd_en = 1'b1; step();
    clr_err = 1'b1; step();
    rd_en = 1'b0;
    tests++; if (udf !== 1'b1) begin fails++; $display("FAIL ar_udf_prio got %b exp 1", udf); end
    step(); clr_err = 1'b0;
    tests++; if (udf !== 1'b0) begin fails++; $display("FAIL ar_udf_clr got %b exp 0", udf); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_push();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_stream();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_32b.md
FIFO_32B -- requirements
Module: fifo_32b

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 32-bit entries; legal values are 2, 4, 8 and 16 (power of two).
REQ-002 The block SHALL have parameter AW, default 2, meaning the pointer width, equal to log2(DEPTH).
REQ-003 Port clk SHALL be an input of width 1: the single clock, with all state updating on its rising edge.
REQ-004 Port rst_n SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-005 Port wr_en SHALL be an input of width 1: push request.
REQ-006 Port wr_data SHALL be an input of width 32: push data.
REQ-007 Port rd_en SHALL be an input of width 1: pop request.
REQ-008 Port rd_data SHALL be an output of width 32: head entry (first-word fall-through); it feeds the downstream 32-bit enabled register.
REQ-009 Port rd_valid SHALL be an output of width 1: high when rd_data holds a real entry; it drives the downstream register's write enable.
REQ-010 Port full SHALL be an output of width 1: count equals DEPTH.
REQ-011 Port empty SHALL be an output of width 1: count equals 0.
REQ-012 Port count SHALL be an output of width AW+1: occupancy, 0..DEPTH.
REQ-013 Port ovf SHALL be an output of width 1: sticky overflow error.
REQ-014 Port udf SHALL be an output of width 1: sticky underflow error.
REQ-015 Port clr_err SHALL be an input of width 1: synchronous clear of ovf and udf.

Function
REQ-016 Storage SHALL be DEPTH x 32 registers, with write pointer wp and read pointer rp, each AW bits, and a count register of AW+1 bits.
REQ-017 A push SHALL be accepted when wr_en=1 and (full=0 or rd_en=1); on acceptance it writes mem[wp] <= wr_data and sets wp <= wp+1, wrapping modulo DEPTH.
REQ-018 A pop SHALL be accepted when rd_en=1 and empty=0; on acceptance it sets rp <= rp+1, wrapping modulo DEPTH.
REQ-019 count SHALL update as +1 on push only, -1 on pop only, and stay unchanged on simultaneous accepted push and pop or when neither is accepted.
REQ-020 When full, simultaneous wr_en and rd_en SHALL both be accepted: the head is popped, the new data is written into the freed slot, and count stays DEPTH.
REQ-021 When empty, simultaneous wr_en and rd_en SHALL accept the push only; the pop is rejected and udf is set.
REQ-022 rd_data SHALL equal mem[rp] combinationally when empty=0, and SHALL be 32'h0 when empty=1.
REQ-023 rd_valid SHALL equal ~empty.
REQ-024 Data written in cycle N SHALL appear on rd_data in cycle N+1 if the FIFO was empty, so the push-to-visible latency is 1 clock.
REQ-025 full and empty SHALL be decoded from the registered count, with no combinational path from wr_en or rd_en.
REQ-026 ovf SHALL be set on any cycle with wr_en=1, full=1 and rd_en=0; the dropped data SHALL NOT alter storage, wp or count.
REQ-027 udf SHALL be set on any cycle with rd_en=1 and empty=1; rp and count SHALL stay unchanged.
REQ-028 clr_err=1 SHALL clear ovf and udf on the next edge, and a set condition in the same cycle SHALL take priority over the clear, leaving the flag at 1.
REQ-029 The FIFO SHALL preserve strict ordering: entries are popped in push order across any number of pointer wraps.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately and asynchronously force wp=0, rp=0, count=0, ovf=0 and udf=0, so that empty=1, full=0, rd_valid=0 and rd_data=32'h0.
REQ-031 Memory contents SHALL NOT be reset; stale entries are unobservable because empty=1 gates rd_data.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries, and the first push after deassertion SHALL appear at rd_data one clock later.
REQ-033 Deassertion of reset is synchronised by the system; the block SHALL require no internal reset synchroniser.

Verification
REQ-034 Reset, then push 32'hA5A5_0001 -> next cycle: rd_valid=1, rd_data=32'hA5A5_0001, count=1.
REQ-035 Push 1,2,3,4 (DEPTH=4) -> full=1, count=4; then push 5 with rd_en=0 -> ovf=1, count=4, and pops return 1,2,3,4 followed by empty=1.
REQ-036 With the FIFO full holding 1..4, push 9 together with pop -> 1 is popped, count=4, and subsequent pops return 2,3,4,9.
REQ-037 With the FIFO empty, assert rd_en together with a push of 32'hDEAD_BEEF -> udf=1, count=1, rd_data=32'hDEAD_BEEF.
REQ-038 Stream 20 pushes and pops at random with values 0..19 -> pointers wrap at least 4 times, output order is 0..19, and ovf=udf=0.
REQ-039 With count=3, pulse rst_n low mid-cycle -> outputs clear asynchronously (count=0, rd_data=0); then assert clr_err together with an underflow -> udf=1.
